// File: rtl/trng_ctrl.sv
// Sequencer for the ring-oscillator TRNG macro: warm-up, divided-rate sampling, word packing,
// repetition-count health test and a valid/ready word handoff.
module trng_ctrl #(
    parameter int unsigned WARMUP_CYCLES = 64,
    parameter int unsigned SAMPLE_DIV    = 4,
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned REP_LIMIT     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  clear_fail_i,
    output logic                  trng_en,
    input  logic                  trng_out,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  health_fail_o,
    output logic                  busy_o
);

    localparam int unsigned WarmW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int unsigned DivW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned BitW  = $clog2(WORD_WIDTH);
    localparam int unsigned RepW  = $clog2(REP_LIMIT + 1);

    localparam logic [WarmW-1:0] WarmLoad = WarmW'(WARMUP_CYCLES - 1);
    localparam logic [DivW-1:0]  DivLast  = DivW'(SAMPLE_DIV - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(WORD_WIDTH - 1);
    localparam logic [RepW-1:0]  RepMax   = RepW'(REP_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StCollect,
        StHold
    } state_t;

    state_t                state;
    logic [WarmW-1:0]      warm_cnt;
    logic [DivW-1:0]       div_cnt;
    logic [BitW-1:0]       bit_cnt;
    logic [RepW-1:0]       rep_cnt;
    logic                  last_bit;
    logic [WORD_WIDTH-1:0] shift;
    logic                  sync1;
    logic                  sync2;

    logic                  strobe;
    logic [RepW-1:0]       rep_next;
    logic [WORD_WIDTH-1:0] shift_next;

    // trng_out is asynchronous to clk; all sampling uses the second flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= trng_out;
            sync2 <= sync1;
        end
    end

    always_comb begin
        strobe     = (state == StCollect) && (div_cnt == DivLast);
        shift_next = {shift[WORD_WIDTH-2:0], sync2};
        // A zero count marks the start of a fresh run after warm-up.
        if ((rep_cnt != '0) && (sync2 == last_bit)) begin
            rep_next = rep_cnt + RepW'(1);
        end else begin
            rep_next = RepW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            warm_cnt      <= '0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            rep_cnt       <= '0;
            last_bit      <= 1'b0;
            shift         <= '0;
            data_o        <= '0;
            valid_o       <= 1'b0;
            trng_en       <= 1'b0;
            health_fail_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            if (clear_fail_i) begin
                health_fail_o <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    trng_en <= 1'b0;
                    busy_o  <= 1'b0;
                    if (enable_i && !health_fail_o) begin
                        state    <= StWarmup;
                        trng_en  <= 1'b1;
                        busy_o   <= 1'b1;
                        warm_cnt <= WarmLoad;
                        rep_cnt  <= '0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end

                StWarmup: begin
                    if (!enable_i) begin
                        state   <= StIdle;
                        trng_en <= 1'b0;
                        busy_o  <= 1'b0;
                    end else if (warm_cnt == '0) begin
                        state   <= StCollect;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        warm_cnt <= warm_cnt - WarmW'(1);
                    end
                end

                StCollect: begin
                    if (!enable_i) begin
                        state   <= StIdle;
                        trng_en <= 1'b0;
                        busy_o  <= 1'b0;
                    end else if (strobe) begin
                        div_cnt  <= '0;
                        rep_cnt  <= rep_next;
                        last_bit <= sync2;
                        if (rep_next == RepMax) begin
                            // Health trip wins over word completion; partial word is dropped.
                            health_fail_o <= 1'b1;
                            state         <= StIdle;
                            trng_en       <= 1'b0;
                            busy_o        <= 1'b0;
                        end else begin
                            shift <= shift_next;
                            if (bit_cnt == BitLast) begin
                                data_o  <= shift_next;
                                valid_o <= 1'b1;
                                state   <= StHold;
                            end else begin
                                bit_cnt <= bit_cnt + BitW'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DivW'(1);
                    end
                end

                StHold: begin
                    trng_en <= enable_i;
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        if (enable_i) begin
                            state   <= StCollect;
                            div_cnt <= '0;
                            bit_cnt <= '0;
                        end else begin
                            state  <= StIdle;
                            busy_o <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed bench for trng_ctrl with small parameters; raw bits are driven so each one is
// captured by the synchronizer two clocks before its sample strobe.
module tb_trng_ctrl;

    localparam int unsigned WU = 8;
    localparam int unsigned SD = 4;
    localparam int unsigned WW = 8;
    localparam int unsigned RL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable_i;
    logic          clear_fail_i;
    logic          trng_en;
    logic          trng_out;
    logic [WW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          health_fail_o;
    logic          busy_o;

    int   total = 0;
    int   bad   = 0;
    logic watch_en   = 1'b0;
    logic en_dropped = 1'b0;

    trng_ctrl #(
        .WARMUP_CYCLES (WU),
        .SAMPLE_DIV    (SD),
        .WORD_WIDTH    (WW),
        .REP_LIMIT     (RL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable_i),
        .clear_fail_i  (clear_fail_i),
        .trng_en       (trng_en),
        .trng_out      (trng_out),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .health_fail_o (health_fail_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (watch_en && !trng_en) en_dropped <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after the COLLECT-entry edge; drives MSB-first bits, one per strobe.
    task automatic feed_bits(input logic [WW-1:0] w, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            trng_out = w[WW-1-k];
            if (k == WW - 1) begin
                tick(3);
                check("pre_valid", valid_o, 0);
                tick(1);
            end else begin
                tick(4);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        enable_i     = 1'b0;
        clear_fail_i = 1'b0;
        ready_i      = 1'b0;
        trng_out     = 1'b0;
        tick(2);
        check("rst_en", trng_en, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_fail", health_fail_o, 0);
        check("rst_busy", busy_o, 0);
        reset = 1'b0;
        tick(1);

        // 1: enable, warm-up, first word at edge 40
        enable_i = 1'b1;
        tick(1);
        check("t1_en", trng_en, 1);
        check("t1_busy", busy_o, 1);
        tick(WU);
        check("t1_warm_valid", valid_o, 0);
        watch_en = 1'b1;
        feed_bits(8'hB2, WW);
        check("t1_valid", valid_o, 1);
        check("t1_data", data_o, 32'hB2);

        // 2: stall, handshake, second word 32 clocks later
        tick(10);
        check("t2_stall_valid", valid_o, 1);
        check("t2_stall_data", data_o, 32'hB2);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        check("t2_hs_valid", valid_o, 0);
        check("t2_hs_en", trng_en, 1);
        feed_bits(8'hD3, WW);
        check("t2_w2_valid", valid_o, 1);
        check("t2_w2_data", data_o, 32'hD3);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        check("t2_w2_hs", valid_o, 0);
        check("t2_en_kept", en_dropped, 0);
        watch_en = 1'b0;

        // 3: abort after 5 strobes, then fresh warm-up
        feed_bits(8'hA5, 5);
        enable_i = 1'b0;
        tick(1);
        check("t3_busy", busy_o, 0);
        check("t3_en", trng_en, 0);
        check("t3_valid", valid_o, 0);
        tick(5);
        check("t3_valid_late", valid_o, 0);
        enable_i = 1'b1;
        tick(1);
        check("t3_re_en", trng_en, 1);
        check("t3_re_busy", busy_o, 1);
        tick(WU);
        feed_bits(8'h5A, WW);
        check("t3_valid2", valid_o, 1);
        check("t3_data2", data_o, 32'h5A);
        enable_i = 1'b0;
        ready_i  = 1'b1;
        tick(1);
        ready_i = 1'b0;
        check("t3_idle_valid", valid_o, 0);
        check("t3_idle_busy", busy_o, 0);

        // 4: stuck-at-1 trips the health test at the 4th strobe
        trng_out = 1'b1;
        enable_i = 1'b1;
        tick(1);
        tick(WU);
        tick(3 * SD);
        check("t4_no_fail3", health_fail_o, 0);
        tick(SD - 1);
        check("t4_no_fail_pre", health_fail_o, 0);
        tick(1);
        check("t4_fail", health_fail_o, 1);
        check("t4_en", trng_en, 0);
        check("t4_busy", busy_o, 0);
        check("t4_valid", valid_o, 0);
        tick(5);
        check("t4_blocked_busy", busy_o, 0);
        check("t4_blocked_en", trng_en, 0);
        check("t4_sticky", health_fail_o, 1);
        clear_fail_i = 1'b1;
        tick(1);
        clear_fail_i = 1'b0;
        check("t4_cleared", health_fail_o, 0);
        check("t4_clr_busy", busy_o, 0);
        tick(1);
        check("t4_warm_busy", busy_o, 1);
        check("t4_warm_en", trng_en, 1);

        // 5: word in HOLD survives enable drop until accepted
        tick(WU);
        feed_bits(8'h96, WW);
        check("t5_valid", valid_o, 1);
        check("t5_data", data_o, 32'h96);
        enable_i = 1'b0;
        tick(1);
        check("t5_en", trng_en, 0);
        check("t5_hold_valid", valid_o, 1);
        check("t5_hold_data", data_o, 32'h96);
        check("t5_hold_busy", busy_o, 1);
        tick(3);
        check("t5_hold_valid2", valid_o, 1);
        ready_i = 1'b1;
        tick(1);
        check("t5_hs_valid", valid_o, 0);
        check("t5_hs_busy", busy_o, 0);
        check("t5_hs_en", trng_en, 0);
        tick(2);
        check("t5_ready_idle_valid", valid_o, 0);
        check("t5_ready_idle_busy", busy_o, 0);
        ready_i = 1'b0;

        // 6: async reset in COLLECT and in HOLD
        enable_i = 1'b1;
        tick(1);
        tick(WU);
        feed_bits(8'h96, 3);
        #2 reset = 1'b1;
        #1;
        check("t6a_en", trng_en, 0);
        check("t6a_busy", busy_o, 0);
        check("t6a_valid", valid_o, 0);
        check("t6a_data", data_o, 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        check("t6_resume_en", trng_en, 1);
        tick(WU);
        feed_bits(8'hB2, WW);
        check("t6_resume_data", data_o, 32'hB2);
        check("t6_resume_valid", valid_o, 1);
        #2 reset = 1'b1;
        #1;
        check("t6b_valid", valid_o, 0);
        check("t6b_data", data_o, 0);
        check("t6b_en", trng_en, 0);
        check("t6b_busy", busy_o, 0);
        check("t6b_fail", health_fail_o, 0);
        tick(1);
        reset    = 1'b0;
        enable_i = 1'b0;
        tick(2);
        check("t6_idle_busy", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
